ray_dispatcher: RTL and testbench
=================================

# ray_dispatcher

Camera-side driver for `ray_tracer_sphere`: on `start` it scans the frame in raster order and issues one primary ray per cycle on the tracer's `init`/`dir` inputs. It collects each `t_out` a fixed `LATENCY` cycles later and writes the depth/hit word to the frame-buffer write port. It sits between the frame control logic and the sphere tracer, and is the producer of everything the tracer consumes on its ray inputs.

## Interface
- `H_RES`, 640, pixels per row (even, ≥2)
- `V_RES`, 480, rows per frame (even, ≥2)
- `FOCAL`, 256, ray z component (1..511)
- `LATENCY`, 4, cycles from `dir` presented to matching `t_out` valid (≥1)
- `MISS_T`, 10'h3FF, `t_out` value meaning no hit
- `ADDR_W`, 19, pixel address width (2^ADDR_W ≥ H_RES·V_RES)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a frame; sampled only in IDLE
- `hold`  in  1  suppress issue this cycle (RUN only)
- `cam_origin`  in  28  camera origin; latched at accepted `start`
- `init`  out  28  ray origin to tracer
- `dir`  out  31  ray direction to tracer, {dx[10:0] signed, dy[10:0] signed, dz[8:0] unsigned}
- `dir_valid`  out  1  `dir` carries a new ray this cycle
- `t_in`  in  10  tracer `t_out`
- `wr_en`  out  1  frame-buffer write strobe
- `wr_addr`  out  ADDR_W  row·H_RES+col
- `wr_data`  out  11  {hit, t}
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle end-of-frame pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 → latch `cam_origin` into `init`; clear col, row and address counters to 0; go to RUN.
- RUN, `hold`=0:
  - Register `dir` = {col − H_RES/2, V_RES/2 − row, FOCAL} and assert `dir_valid`.
  - Push {1, address} into a LATENCY-deep tag pipeline.
  - Advance col; when col wraps at H_RES−1, col←0 and row++.
  - Address increments by 1.
- RUN, `hold`=1:
  - `dir_valid`=0; counters and `dir` frozen.
  - Push a bubble {0, x} into the tag pipeline.
- The ray for the last pixel (H_RES−1, V_RES−1) is the final issue → DRAIN.
- DRAIN:
  - Push bubbles until the tag pipeline holds no valid entry and the final write has been emitted → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Writeback: when the tag pipeline's output entry is valid, register `wr_en`=1, `wr_addr`=tag, `wr_data`={`t_in`≠MISS_T, `t_in`}.
- dx/dy are 11-bit two's complement. No saturation is needed because |H_RES/2|, |V_RES/2| < 1024. dz is a constant.
- `start` in RUN, DRAIN or DONE is ignored.
- `hold` is ignored outside RUN. `hold` never stalls the tracer or writeback; in-flight rays always complete.
- `rst` in any state:
  - Next state IDLE.
  - Tag pipeline cleared, so in-flight results are discarded and no `wr_en` follows.
  - Counters cleared.

## Timing
- Reset values: `init`=0, `dir`=0, `dir_valid`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0 → RUN from E0. The first `dir_valid` is high in the cycle after E1 (cycle 1, relative to E0 = cycle 0); `busy`=1 from cycle 1.
- A ray issued in cycle n has `t_in` sampled at the end of cycle n+LATENCY. `wr_en` is high during cycle n+LATENCY+1.
- Throughput is one ray per cycle with `hold`=0. A full frame takes H_RES·V_RES + (cycles with `hold`=1) issue cycles.
- `done` is high the cycle after the last `wr_en`. `busy` is 0 in the cycle after `done`, and a new `start` is accepted in that same cycle.
- `wr_addr` strictly increments by 1 across writes within a frame, with no gaps or duplicates, regardless of `hold` pattern.

## Test plan
- **Basic frame.** H_RES=4, V_RES=2, LATENCY=3, FOCAL=256; `start` at cycle 0, tracer model returns t=5.
  - 8 rays in cycles 1–8.
  - First `dir` = {11'h7FE, 11'h001, 9'h100}; last `dir` = {11'h001, 11'h000, 9'h100}.
  - `wr_en` in cycles 5–12 with addr 0..7 and `wr_data`=11'h405.
  - `done` in cycle 13.
- **Miss encoding.** Tracer returns 10'h3FF for odd addresses and 10'h010 for even → `wr_data` alternates 11'h410 / 11'h3FF.
- **Hold.** `hold`=1 in cycles 3–4 → no `dir_valid` in those cycles, `dir` stable. Writes still cover addr 0..7 exactly once, and `done` shifts to cycle 15.
- **Start while busy.** `start` pulsed in cycle 4 → ignored; exactly 8 writes, and `cam_origin` changes made at that time do not alter `init`.
- **Reset mid-frame.** `rst` in cycle 6 → from cycle 7 all outputs equal their reset values; no `wr_en` after cycle 7. A following `start` produces a clean frame from addr 0.
- **Back-to-back.** `start` held high continuously → second frame's first `dir_valid` falls exactly 2 cycles after the first `done`, and its `wr_addr` restarts at 0.

Source files
------------

// File: rtl/ray_dispatcher.sv
// ---------------------------------------------------------------------------
// ray_dispatcher
//   Camera-side driver for the sphere tracer. On an accepted start it walks
//   the frame in raster order and issues one primary ray per cycle. A tag
//   pipeline follows each ray through the tracer's fixed latency, so every
//   returned t value can be written to the frame buffer at its pixel address.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           begin a frame (sampled only in IDLE)
//   hold            skip issue this cycle (RUN only)
//   cam_origin      camera origin, latched into init at accepted start
//   init            ray origin to tracer
//   dir             {dx[10:0] signed, dy[10:0] signed, dz[8:0] unsigned}
//   dir_valid       dir carries a new ray this cycle
//   t_in            tracer t_out
//   wr_en/addr/data frame-buffer write port, data = {hit, t}
//   busy            frame in progress
//   done            one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module ray_dispatcher #(
    parameter int         H_RES   = 640,
    parameter int         V_RES   = 480,
    parameter int         FOCAL   = 256,
    parameter int         LATENCY = 4,
    parameter logic [9:0] MISS_T  = 10'h3FF,
    parameter int         ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic [27:0]       cam_origin,
    output logic [27:0]       init,
    output logic [30:0]       dir,
    output logic              dir_valid,
    input  logic [9:0]        t_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [10:0]       wr_data,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;

    // Tag pipeline: entry 0 is loaded with the ray issue, entry LATENCY lines
    // up with the cycle in which the tracer presents that ray's t value.
    logic [LATENCY:0]  r_tag_vld;
    logic [ADDR_W-1:0] r_tag_addr [0:LATENCY];

    logic w_issue;
    logic w_last;
    logic w_inflight;

    // Two's-complement direction; |H_RES/2|, |V_RES/2| < 1024 so no overflow.
    function automatic logic [30:0] pack_dir(input logic [COL_W-1:0] col,
                                             input logic [ROW_W-1:0] row);
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        dx = 11'(col) - 11'(H_RES / 2);
        dy = 11'(V_RES / 2) - 11'(row);
        return {dx, dy, 9'(FOCAL)};
    endfunction

    assign w_issue    = (r_state == S_RUN) && !hold;
    assign w_last     = (r_col == COL_W'(H_RES - 1)) && (r_row == ROW_W'(V_RES - 1));
    // Entry LATENCY is being written out this edge, so only earlier entries
    // count as still in flight.
    assign w_inflight = |r_tag_vld[LATENCY-1:0];

    // ---- issue stage: FSM, raster counters, ray outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            init      <= '0;
            dir       <= '0;
            dir_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            dir_valid <= 1'b0;
            done      <= 1'b0;
            // DONE reports busy for its own cycle; IDLE drops it next cycle.
            busy      <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        init    <= cam_origin;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_addr  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        dir       <= pack_dir(r_col, r_row);
                        dir_valid <= 1'b1;
                        r_addr    <= r_addr + ADDR_W'(1);
                        if (r_col == COL_W'(H_RES - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_inflight) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---- tag pipeline: valid bits reset, addresses are pure data ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[LATENCY-1:0], w_issue};
        end
    end

    always_ff @(posedge clk) begin
        r_tag_addr[0] <= r_addr;
        for (int i = 1; i <= LATENCY; i++) begin
            r_tag_addr[i] <= r_tag_addr[i-1];
        end
    end

    // ---- writeback stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= r_tag_vld[LATENCY];
            if (r_tag_vld[LATENCY]) begin
                wr_addr <= r_tag_addr[LATENCY];
                wr_data <= {(t_in != MISS_T), t_in};
            end
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
module tb_ray_dispatcher;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int L  = 3;
    localparam int AW = 3;
    localparam int NC = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
    logic [27:0]   cam_origin;
    logic [27:0]   init;
    logic [30:0]   dir;
    logic          dir_valid;
    logic [9:0]    t_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [10:0]   wr_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ray_dispatcher #(
        .H_RES(H), .V_RES(V), .FOCAL(256), .LATENCY(L),
        .MISS_T(10'h3FF), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .cam_origin(cam_origin), .init(init), .dir(dir), .dir_valid(dir_valid),
        .t_in(t_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    // Stimulus per edge index (value sampled at edge Ec) and per-cycle log.
    logic          st_start [NC];
    logic          st_hold  [NC];
    logic          st_rst   [NC];
    logic [27:0]   st_org   [NC];
    logic          lg_dv    [NC];
    logic [30:0]   lg_dir   [NC];
    logic [27:0]   lg_init  [NC];
    logic          lg_we    [NC];
    logic [AW-1:0] lg_wa    [NC];
    logic [10:0]   lg_wd    [NC];
    logic          lg_done  [NC];
    logic          lg_busy  [NC];

    int tmode;
    int n_tests;
    int n_fail;

    function automatic logic [9:0] tfun(input int idx);
        if (tmode == 1) return (idx % 2 == 1) ? 10'h3FF : 10'h010;
        return 10'd5;
    endfunction

    task automatic clr();
        for (int c = 0; c < NC; c++) begin
            st_start[c] = 1'b0;
            st_hold[c]  = 1'b0;
            st_rst[c]   = 1'b0;
            st_org[c]   = '0;
        end
        tmode = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; hold = 1'b0; t_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycle c runs from edge Ec to E(c+1); the tracer model answers the ray
    // seen in cycle c-L during cycle c.
    task automatic run(input int n);
        int nray;
        int ridx [NC];
        nray = 0;
        for (int c = 0; c < NC; c++) ridx[c] = -1;
        start = st_start[0]; hold = st_hold[0]; rst = st_rst[0]; cam_origin = st_org[0];
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (c + 1 < NC) begin
                start = st_start[c+1]; hold = st_hold[c+1];
                rst = st_rst[c+1]; cam_origin = st_org[c+1];
            end
            @(negedge clk);
            lg_dv[c] = dir_valid; lg_dir[c] = dir; lg_init[c] = init;
            lg_we[c] = wr_en; lg_wa[c] = wr_addr; lg_wd[c] = wr_data;
            lg_done[c] = done; lg_busy[c] = busy;
            if (dir_valid) begin
                ridx[c] = nray;
                nray++;
            end
            if (c >= L && ridx[c-L] >= 0) t_in = tfun(ridx[c-L]);
            else t_in = 10'h2AA;
        end
        start = 1'b0; hold = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hold = 1'b0; cam_origin = 28'hFFFFFFF; t_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (init !== 28'h0) begin n_fail++; $display("FAIL reset_init: got %h want 0", init); end
        n_tests++;
        if (dir !== 31'h0) begin n_fail++; $display("FAIL reset_dir: got %h want 0", dir); end
        n_tests++;
        if ({dir_valid, wr_en, busy, done} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {dir_valid, wr_en, busy, done});
        end
        n_tests++;
        if ({wr_addr, wr_data} !== '0) begin
            n_fail++; $display("FAIL reset_wr: got addr %h data %h want 0", wr_addr, wr_data);
        end
    endtask

    task automatic test_basic();
        logic        edv, ewe, edn, ebz;
        logic [10:0] ex, ey;
        logic [30:0] ed;
        int k;
        do_reset(); clr();
        st_start[0] = 1'b1;
        for (int c = 0; c < NC; c++) st_org[c] = 28'hABCDEF1;
        run(16);
        n_tests++;
        if (lg_dir[1] !== {11'h7FE, 11'h001, 9'h100}) begin
            n_fail++; $display("FAIL basic_first_dir: got %h want %h", lg_dir[1], {11'h7FE, 11'h001, 9'h100});
        end
        n_tests++;
        if (lg_dir[8] !== {11'h001, 11'h000, 9'h100}) begin
            n_fail++; $display("FAIL basic_last_dir: got %h want %h", lg_dir[8], {11'h001, 11'h000, 9'h100});
        end
        n_tests++;
        if (lg_init[1] !== 28'hABCDEF1) begin
            n_fail++; $display("FAIL basic_init: got %h want abcdef1", lg_init[1]);
        end
        for (int c = 0; c < 16; c++) begin
            edv = (c >= 1 && c <= 8);
            ewe = (c >= 5 && c <= 12);
            edn = (c == 13);
            ebz = (c >= 1 && c <= 13);
            n_tests++;
            if (lg_dv[c] !== edv) begin n_fail++; $display("FAIL basic_dv c%0d: got %b want %b", c, lg_dv[c], edv); end
            if (edv) begin
                k  = c - 1;
                ex = 11'((k % H) - H / 2);
                ey = 11'(V / 2 - (k / H));
                ed = {ex, ey, 9'h100};
                n_tests++;
                if (lg_dir[c] !== ed) begin n_fail++; $display("FAIL basic_dir c%0d: got %h want %h", c, lg_dir[c], ed); end
            end
            n_tests++;
            if (lg_we[c] !== ewe) begin n_fail++; $display("FAIL basic_we c%0d: got %b want %b", c, lg_we[c], ewe); end
            if (ewe) begin
                n_tests++;
                if (lg_wa[c] !== AW'(c - 5) || lg_wd[c] !== 11'h405) begin
                    n_fail++; $display("FAIL basic_wr c%0d: got %h/%h want %h/405", c, lg_wa[c], lg_wd[c], AW'(c - 5));
                end
            end
            n_tests++;
            if (lg_done[c] !== edn) begin n_fail++; $display("FAIL basic_done c%0d: got %b want %b", c, lg_done[c], edn); end
            n_tests++;
            if (lg_busy[c] !== ebz) begin n_fail++; $display("FAIL basic_busy c%0d: got %b want %b", c, lg_busy[c], ebz); end
        end
    endtask

    task automatic test_miss();
        logic [10:0] ew;
        do_reset(); clr();
        tmode = 1;
        st_start[0] = 1'b1;
        run(16);
        for (int c = 5; c <= 12; c++) begin
            ew = ((c - 5) % 2 == 1) ? 11'h3FF : 11'h410;
            n_tests++;
            if (lg_we[c] !== 1'b1 || lg_wd[c] !== ew) begin
                n_fail++; $display("FAIL miss_data c%0d: got we %b data %h want 1/%h", c, lg_we[c], lg_wd[c], ew);
            end
        end
    endtask

    task automatic test_hold();
        logic edv, ewe;
        int ea;
        do_reset(); clr();
        st_start[0] = 1'b1;
        st_hold[3] = 1'b1;
        st_hold[4] = 1'b1;
        run(18);
        ea = 0;
        for (int c = 0; c < 18; c++) begin
            edv = (c == 1 || c == 2 || (c >= 5 && c <= 10));
            ewe = (c == 5 || c == 6 || (c >= 9 && c <= 14));
            n_tests++;
            if (lg_dv[c] !== edv) begin n_fail++; $display("FAIL hold_dv c%0d: got %b want %b", c, lg_dv[c], edv); end
            n_tests++;
            if (lg_we[c] !== ewe) begin n_fail++; $display("FAIL hold_we c%0d: got %b want %b", c, lg_we[c], ewe); end
            if (lg_we[c] === 1'b1) begin
                n_tests++;
                if (lg_wa[c] !== AW'(ea)) begin n_fail++; $display("FAIL hold_addr c%0d: got %h want %h", c, lg_wa[c], AW'(ea)); end
                ea++;
            end
            n_tests++;
            if (lg_done[c] !== (c == 15)) begin n_fail++; $display("FAIL hold_done c%0d: got %b want %b", c, lg_done[c], (c == 15)); end
        end
        for (int c = 3; c <= 4; c++) begin
            n_tests++;
            if (lg_dir[c] !== {11'h7FF, 11'h001, 9'h100}) begin
                n_fail++; $display("FAIL hold_dir_stable c%0d: got %h want %h", c, lg_dir[c], {11'h7FF, 11'h001, 9'h100});
            end
        end
        n_tests++;
        if (ea != 8) begin n_fail++; $display("FAIL hold_wcount: got %0d want 8", ea); end
    endtask

    task automatic test_start_busy();
        int nw, nd;
        do_reset(); clr();
        st_start[0] = 1'b1;
        st_start[4] = 1'b1;
        st_start[5] = 1'b1;
        st_org[0] = 28'h1234567;
        for (int c = 1; c < NC; c++) st_org[c] = 28'hFEDCBA9;
        run(16);
        nw = 0; nd = 0;
        for (int c = 1; c < 16; c++) begin
            n_tests++;
            if (lg_init[c] !== 28'h1234567) begin n_fail++; $display("FAIL sb_init c%0d: got %h want 1234567", c, lg_init[c]); end
            if (lg_we[c] === 1'b1) nw++;
            if (lg_done[c] === 1'b1) nd++;
        end
        n_tests++;
        if (nw != 8) begin n_fail++; $display("FAIL sb_wcount: got %0d want 8", nw); end
        n_tests++;
        if (nd != 1 || lg_done[13] !== 1'b1) begin n_fail++; $display("FAIL sb_done: got count %0d c13 %b want 1/1", nd, lg_done[13]); end
    endtask

    task automatic test_reset_mid();
        logic [98:0] allout;
        do_reset(); clr();
        st_start[0] = 1'b1;
        st_org[0] = 28'h5555555;
        st_rst[7] = 1'b1;
        run(14);
        n_tests++;
        if (lg_we[5] !== 1'b1 || lg_we[6] !== 1'b1 || lg_wa[6] !== 3'd1) begin
            n_fail++; $display("FAIL rm_prewrites: got %b%b addr %h want 11/1", lg_we[5], lg_we[6], lg_wa[6]);
        end
        for (int c = 7; c < 14; c++) begin
            allout = {lg_init[c], lg_dir[c], lg_dv[c], lg_we[c], lg_wa[c], lg_wd[c], lg_busy[c], lg_done[c], 21'h0};
            n_tests++;
            if (allout !== '0) begin n_fail++; $display("FAIL rm_cleared c%0d: got %h want 0", c, allout); end
        end
        clr();
        st_start[0] = 1'b1;
        st_org[0] = 28'h0C0FFEE;
        run(16);
        for (int c = 5; c <= 12; c++) begin
            n_tests++;
            if (lg_we[c] !== 1'b1 || lg_wa[c] !== AW'(c - 5)) begin
                n_fail++; $display("FAIL rm_refill c%0d: got we %b addr %h want 1/%h", c, lg_we[c], lg_wa[c], AW'(c - 5));
            end
        end
        n_tests++;
        if (lg_init[1] !== 28'h0C0FFEE) begin n_fail++; $display("FAIL rm_init: got %h want 0c0ffee", lg_init[1]); end
    endtask

    task automatic test_back_to_back();
        do_reset(); clr();
        for (int c = 0; c < NC; c++) st_start[c] = 1'b1;
        run(30);
        n_tests++;
        if (lg_done[13] !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b want 1", lg_done[13]); end
        n_tests++;
        if (lg_busy[14] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy14: got %b want 0", lg_busy[14]); end
        n_tests++;
        if (lg_dv[14] !== 1'b0 || lg_dv[15] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_dv: got c14 %b c15 %b want 0/1", lg_dv[14], lg_dv[15]);
        end
        n_tests++;
        if (lg_dir[15] !== {11'h7FE, 11'h001, 9'h100}) begin
            n_fail++; $display("FAIL b2b_first_dir: got %h want %h", lg_dir[15], {11'h7FE, 11'h001, 9'h100});
        end
        for (int c = 13; c <= 18; c++) begin
            n_tests++;
            if (lg_we[c] !== 1'b0) begin n_fail++; $display("FAIL b2b_gap c%0d: got %b want 0", c, lg_we[c]); end
        end
        n_tests++;
        if (lg_we[19] !== 1'b1 || lg_wa[19] !== 3'd0) begin
            n_fail++; $display("FAIL b2b_restart: got we %b addr %h want 1/0", lg_we[19], lg_wa[19]);
        end
        n_tests++;
        if (lg_done[27] !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b want 1", lg_done[27]); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr();
        test_reset();
        test_basic();
        test_miss();
        test_hold();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
